decode_issue: RTL

- Decode/issue stage directly upstream of the execute ALU.
- Accepts 32-bit instructions over a valid/ready handshake, decodes R-type (opcode 0110011) operations into the 7-bit ALU control code, reads both source operands from an internal 32x32 register file, and presents control, operands and destination register to the ALU in a one-entry output register.
- A per-register pending scoreboard stalls issue on RAW/WAW hazards until the downstream writeback port retires the producing instruction.

---
 rtl/isa_pkg.sv | 83 ++++++++
 rtl/decode_issue_if.sv | 32 +++
 rtl/decode_issue_reg_file.sv | 42 ++++
 rtl/decode_issue.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode/issue stage: R-type opcode,
// funct3/funct7 encodings, ALU control codes, register index type and the
// R-type decode helper.
package isa_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0] reg_idx_t;

  localparam logic [6:0] OP_R = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [6:0] ALU_ADD  = 7'd0;
  localparam logic [6:0] ALU_SUB  = 7'd1;
  localparam logic [6:0] ALU_XOR  = 7'd2;
  localparam logic [6:0] ALU_OR   = 7'd3;
  localparam logic [6:0] ALU_AND  = 7'd4;
  localparam logic [6:0] ALU_SLL  = 7'd5;
  localparam logic [6:0] ALU_SRL  = 7'd6;
  localparam logic [6:0] ALU_SRA  = 7'd7;
  localparam logic [6:0] ALU_SLT  = 7'd8;
  localparam logic [6:0] ALU_SLTU = 7'd9;

  typedef struct packed {
    logic       legal;
    logic [6:0] ctrl;
  } dec_t;

  // Map an instruction word to its ALU control code; anything that is not
  // a recognised R-type funct3/funct7 pair comes back with legal=0.
  function automatic dec_t decode_r(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] f7;
    f7      = instr[31:25];
    d.legal = 1'b0;
    d.ctrl  = ALU_ADD;
    if (instr[6:0] == OP_R) begin
      case (instr[14:12])
        F3_ADD: begin
          if (f7 == F7_BASE) begin
            d.legal = 1'b1; d.ctrl = ALU_ADD;
          end else if (f7 == F7_ALT) begin
            d.legal = 1'b1; d.ctrl = ALU_SUB;
          end else begin
            d.legal = 1'b0;
          end
        end
        F3_SR: begin
          if (f7 == F7_BASE) begin
            d.legal = 1'b1; d.ctrl = ALU_SRL;
          end else if (f7 == F7_ALT) begin
            d.legal = 1'b1; d.ctrl = ALU_SRA;
          end else begin
            d.legal = 1'b0;
          end
        end
        F3_XOR:  begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_XOR;  end
        F3_OR:   begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_OR;   end
        F3_AND:  begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_AND;  end
        F3_SLL:  begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_SLL;  end
        F3_SLT:  begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_SLT;  end
        F3_SLTU: begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_SLTU; end
        default: begin d.legal = 1'b0; d.ctrl = ALU_ADD; end
      endcase
    end else begin
      d.legal = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Bundle of the decode/issue stage's instruction input, ALU-side output,
// writeback port and status flags. master = environment, slave = stage.
interface decode_issue_if;
  import isa_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_control;
  logic [XLEN-1:0] out_input1;
  logic [XLEN-1:0] out_input2;
  reg_idx_t        out_rd;
  logic            illegal;
  logic            wb_valid;
  reg_idx_t        wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy;

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
    input  in_ready, out_valid, out_control, out_input1, out_input2, out_rd,
           illegal, busy
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
    output in_ready, out_valid, out_control, out_input1, out_input2, out_rd,
           illegal, busy
  );
endinterface

// File: rtl/decode_issue_reg_file.sv
// reg_file: 32 x XLEN register file, two combinational read ports, one
// write port, x0 hardwired to zero, asynchronous active-low clear.
module reg_file
  import isa_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  reg_idx_t        ra1,
  input  reg_idx_t        ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  reg_idx_t        wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next-state array: apply the single write, never to x0.
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) begin
      regs_d[wa] = wd;
    end else begin
      regs_d[0] = {XLEN{1'b0}};
    end
  end

  // Register storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= {XLEN{1'b0}};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? {XLEN{1'b0}} : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? {XLEN{1'b0}} : regs_q[ra2];

endmodule

// File: rtl/decode_issue.sv
// decode_issue: R-type decode, register read, pending-bit scoreboard and a
// one-entry output register feeding the ALU.
// Optional feature macro: WB_BYPASS_EN (same-cycle writeback forwarding).
module decode_issue
  import isa_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  decode_issue_if.slave bus
);

  reg_idx_t        rs1_s, rs2_s, rd_s;
  dec_t            dec_s;
  logic [XLEN-1:0] rf_rd1_s, rf_rd2_s, op1_s, op2_s;
  logic [NREGS-1:0] pend_eff_s, wb_mask_s;
  logic            hazard_s, accept_s, accept_legal_s;

  logic [NREGS-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [6:0]       out_control_q, out_control_d;
  logic [XLEN-1:0]  out_input1_q, out_input1_d;
  logic [XLEN-1:0]  out_input2_q, out_input2_d;
  reg_idx_t         out_rd_q, out_rd_d;
  logic             illegal_q, illegal_d;

  assign rs1_s = bus.in_instr[19:15];
  assign rs2_s = bus.in_instr[24:20];
  assign rd_s  = bus.in_instr[11:7];
  assign dec_s = decode_r(bus.in_instr);

  reg_file u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1_s),
    .ra2   (rs2_s),
    .rd1   (rf_rd1_s),
    .rd2   (rf_rd2_s),
    .we    (bus.wb_valid),
    .wa    (bus.wb_rd),
    .wd    (bus.wb_data)
  );

  // Effective pending bits and operand values for this cycle's hazard check.
  always_comb begin
    wb_mask_s = {NREGS{1'b0}};
    if (bus.wb_valid) begin
      wb_mask_s[bus.wb_rd] = 1'b1;
    end else begin
      wb_mask_s = {NREGS{1'b0}};
    end
`ifdef WB_BYPASS_EN
    pend_eff_s = pending_q & ~wb_mask_s;
    if (bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1_s)) begin
      op1_s = bus.wb_data;
    end else begin
      op1_s = rf_rd1_s;
    end
    if (bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2_s)) begin
      op2_s = bus.wb_data;
    end else begin
      op2_s = rf_rd2_s;
    end
`else
    pend_eff_s = pending_q;
    op1_s      = rf_rd1_s;
    op2_s      = rf_rd2_s;
`endif
  end

  assign hazard_s       = bus.in_valid & dec_s.legal &
                          (pend_eff_s[rs1_s] | pend_eff_s[rs2_s] | pend_eff_s[rd_s]);
  assign bus.in_ready   = (!out_valid_q || bus.out_ready) && !hazard_s;
  assign accept_s       = bus.in_valid & bus.in_ready;
  assign accept_legal_s = accept_s & dec_s.legal;

  // Scoreboard update: writeback clears, issue sets; set is applied last so it wins.
  always_comb begin
    pending_d = pending_q;
    if (bus.wb_valid) begin
      pending_d[bus.wb_rd] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (accept_legal_s) begin
      pending_d[rd_s] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // Output slot: load on legal accept, hold while stalled, drain on consume.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_control_d = out_control_q;
    out_input1_d  = out_input1_q;
    out_input2_d  = out_input2_q;
    out_rd_d      = out_rd_q;
    illegal_d     = accept_s & ~dec_s.legal;
    if (accept_legal_s) begin
      out_valid_d   = 1'b1;
      out_control_d = dec_s.ctrl;
      out_input1_d  = op1_s;
      out_input2_d  = op2_s;
      out_rd_d      = rd_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= {NREGS{1'b0}};
      out_valid_q   <= 1'b0;
      out_control_q <= 7'd0;
      out_input1_q  <= {XLEN{1'b0}};
      out_input2_q  <= {XLEN{1'b0}};
      out_rd_q      <= 5'd0;
      illegal_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      out_valid_q   <= out_valid_d;
      out_control_q <= out_control_d;
      out_input1_q  <= out_input1_d;
      out_input2_q  <= out_input2_d;
      out_rd_q      <= out_rd_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_control = out_control_q;
  assign bus.out_input1  = out_input1_q;
  assign bus.out_input2  = out_input2_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.illegal     = illegal_q;
  assign bus.busy        = (|pending_q) | out_valid_q;

endmodule
